// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM encoding and counter sizing.
// Optional OVF_FLAG_EN build adds a signed-overflow flag to serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; WIDTH+1 keeps WIDTH=1 at one bit.
  function automatic int cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit combinational full adder cell used by the serial datapath.
// Pure logic, no state.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus carry flop.
// Define OVF_FLAG_EN to add the ovf (2's-complement overflow) output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_n;
  logic             carry;
  logic             s;
  logic             c;
  logic             load;
  logic             step;
  logic             last;

  fa u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .c    (carry),
    .sum  (s),
    .carry(c)
  );

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // New bit enters at the MSB; works for WIDTH=1 too.
  always_comb begin
    sum_n = sum >> 1;
    sum_n[WIDTH-1] = s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else if (step) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= c;
      count <= count + CW'(1);
      sum   <= sum_n;
      if (last) begin
        cout <= c;
`ifdef OVF_FLAG_EN
        // carry still holds the carry into the MSB here
        ovf  <= carry ^ c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): table vectors plus corner sequences.
// Builds with or without OVF_FLAG_EN.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       cout;
`ifdef OVF_FLAG_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    int cap;
    logic [4:0] model;

    vt[0] = '{4'd0,  4'd0,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[1] = '{4'd7,  4'd9,  1'b0, 4'h0, 1'b1, 1'b0};
    vt[2] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
    vt[3] = '{4'd7,  4'd1,  1'b0, 4'h8, 1'b0, 1'b1};
    vt[4] = '{4'd8,  4'd8,  1'b0, 4'h0, 1'b1, 1'b1};
    vt[5] = '{4'd3,  4'd2,  1'b0, 4'h5, 1'b0, 1'b0};
    vt[6] = '{4'd10, 4'd5,  1'b1, 4'h0, 1'b1, 1'b0};
    vt[7] = '{4'd4,  4'd3,  1'b1, 4'h8, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
`ifdef OVF_FLAG_EN
    chk("rst_ovf", int'(ovf), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, lat, bcnt);
      model = 5'(vt[i].a) + 5'(vt[i].b) + 5'(vt[i].cin);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 4);
      chk($sformatf("v%0d_sum", i), int'(sum), int'(vt[i].s));
      chk($sformatf("v%0d_cout", i), int'(cout), int'(vt[i].co));
      chk($sformatf("v%0d_model", i), int'({cout, sum}), int'(model));
`ifdef OVF_FLAG_EN
      chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vt[i].ov));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_sum_held", i), int'(sum), int'(vt[i].s));
    end

    // start while busy is ignored
    @(negedge clk);
    a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd0; b = 4'd0;
    dcnt = 0;
    cap = -1;
    repeat (14) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 1) cap = int'(sum);
      end
    end
    chk("busy_start_done_count", dcnt, 1);
    chk("busy_start_sum", cap, 7);

    // reset in the second shift cycle aborts
    @(negedge clk);
    a = 4'd7; b = 4'd0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_cout", int'(cout), 0);
    chk("abort_done", int'(done), 0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 4'd1; b = 4'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", int'(busy), 0);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("rst_start_dropped", dcnt, 0);

    // back-to-back: start held into DONE
    @(negedge clk);
    a = 4'd2; b = 4'd3; cin = 1'b0; start = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_latency", lat, 5);
    chk("b2b_first_sum", int'(sum), 5);
    a = 4'd5; b = 4'd6;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_gap", lat, 5);
    chk("b2b_sum", int'(sum), 11);
    chk("b2b_cout", int'(cout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
